multi_cycle_ctrl: RTL

//   Multi-cycle sequencer for the MIPS datapath (regfile, ALU, extender, data memory).

---
 rtl/multi_cycle_ctrl.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/multi_cycle_ctrl.sv
// Purpose: multi-cycle IF/ID/EX/MEM/WB sequencer for the MIPS datapath. It registers the decode in ID and issues per-state enables.
// Latency: R/I-type and sw take 4 cycles and lw takes 5, with one extra cycle per dmem wait cycle.
// Backpressure: MEM holds while dmem_ready is low. After MEM_TIMEOUT cycles it aborts with a bus_err pulse.
// Ports:
//   clk/rst        - clock and synchronous active-high reset
//   op/funct       - instruction fields from the IR
//   dmem_ready     - data memory completion
//   ir_write, pc_write, dmem_req, mem_write, reg_write - one-state enables
//   alu_src, if_extend, reg_dst, memtoreg, aluop       - decode, held from ID to the next ID
//   illegal, bus_err                                    - single-cycle error pulses
//   state, instret                                      - debug state and retired-instruction count
module multi_cycle_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             dmem_ready,
    output logic             ir_write,
    output logic             pc_write,
    output logic             alu_src,
    output logic             if_extend,
    output logic             reg_dst,
    output logic             memtoreg,
    output logic [4:0]       aluop,
    output logic             dmem_req,
    output logic             mem_write,
    output logic             reg_write,
    output logic             illegal,
    output logic             bus_err,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instret
);

    localparam logic [2:0] S_IF  = 3'd0;
    localparam logic [2:0] S_ID  = 3'd1;
    localparam logic [2:0] S_EX  = 3'd2;
    localparam logic [2:0] S_MEM = 3'd3;
    localparam logic [2:0] S_WB  = 3'd4;

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic [7:0]       wait_q, wait_d;
    logic             alu_src_q, if_extend_q, reg_dst_q, memtoreg_q;
    logic [4:0]       aluop_q;
    logic             is_lw_q, is_sw_q;

    logic             dec_ok, dec_src, dec_ext, dec_dst, dec_lw, dec_sw;
    logic [4:0]       dec_aluop;
    logic             illegal_c, bus_err_c;

    // Instruction decode. This logic only feeds registers that are loaded in ID.
    always_comb begin
        dec_ok    = 1'b1;
        dec_src   = 1'b0;
        dec_ext   = 1'b0;
        dec_dst   = 1'b0;
        dec_lw    = 1'b0;
        dec_sw    = 1'b0;
        dec_aluop = 5'd0;
        case (op)
            6'h00: begin
                case (funct)
                    6'h20:   dec_aluop = 5'd0;
                    6'h21:   dec_aluop = 5'd1;
                    6'h23:   dec_aluop = 5'd2;
                    6'h24:   dec_aluop = 5'd3;
                    6'h25:   dec_aluop = 5'd4;
                    6'h2A:   dec_aluop = 5'd5;
                    default: dec_ok    = 1'b0;
                endcase
            end
            6'h08: {dec_src, dec_ext, dec_dst, dec_aluop} = {3'b111, 5'd0};
            6'h09: {dec_src, dec_ext, dec_dst, dec_aluop} = {3'b111, 5'd1};
            6'h0C: {dec_src, dec_ext, dec_dst, dec_aluop} = {3'b101, 5'd3};
            6'h0D: {dec_src, dec_ext, dec_dst, dec_aluop} = {3'b101, 5'd4};
            6'h0F: {dec_src, dec_ext, dec_dst, dec_aluop} = {3'b111, 5'd6};
            6'h23: begin
                {dec_src, dec_ext, dec_dst, dec_aluop} = {3'b111, 5'd0};
                dec_lw = 1'b1;
            end
            6'h2B: begin
                {dec_src, dec_ext, dec_dst, dec_aluop} = {3'b111, 5'd0};
                dec_sw = 1'b1;
            end
            default: dec_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        instret_d = instret_q;
        wait_d    = wait_q;
        illegal_c = 1'b0;
        bus_err_c = 1'b0;
        case (state_q)
            S_IF: state_d = S_ID;
            S_ID: begin
                if (dec_ok) begin
                    state_d = S_EX;
                end else begin
                    illegal_c = 1'b1;
                    state_d   = S_IF;
                end
            end
            S_EX: begin
                state_d = (is_lw_q || is_sw_q) ? S_MEM : S_WB;
                wait_d  = 8'd0;
            end
            S_MEM: begin
                // When ready and the timeout land in the same cycle, ready wins.
                if (dmem_ready) begin
                    wait_d = 8'd0;
                    if (is_sw_q) begin
                        state_d   = S_IF;
                        instret_d = instret_q + CNT_W'(1);
                    end else begin
                        state_d = S_WB;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    bus_err_c = 1'b1;
                    wait_d    = 8'd0;
                    state_d   = S_IF;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_WB: begin
                state_d   = S_IF;
                instret_d = instret_q + CNT_W'(1);
            end
            default: state_d = S_IF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IF;
            instret_q   <= '0;
            wait_q      <= 8'd0;
            alu_src_q   <= 1'b0;
            if_extend_q <= 1'b0;
            reg_dst_q   <= 1'b0;
            memtoreg_q  <= 1'b0;
            aluop_q     <= 5'd0;
            is_lw_q     <= 1'b0;
            is_sw_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
            wait_q    <= wait_d;
            if (state_q == S_ID) begin
                alu_src_q   <= dec_src;
                if_extend_q <= dec_ext;
                reg_dst_q   <= dec_dst;
                memtoreg_q  <= dec_lw;
                aluop_q     <= dec_aluop;
                is_lw_q     <= dec_lw;
                is_sw_q     <= dec_sw;
            end
        end
    end

    // The enables are decoded from the state only. They are masked while rst is high,
    // so nothing fires during the reset cycle.
    assign ir_write  = (state_q == S_IF)  && !rst;
    assign pc_write  = (state_q == S_IF)  && !rst;
    assign dmem_req  = (state_q == S_MEM) && !rst;
    assign mem_write = (state_q == S_MEM) && is_sw_q && !rst;
    assign reg_write = (state_q == S_WB)  && !rst;
    assign illegal   = illegal_c && !rst;
    assign bus_err   = bus_err_c && !rst;

    assign alu_src   = alu_src_q;
    assign if_extend = if_extend_q;
    assign reg_dst   = reg_dst_q;
    assign memtoreg  = memtoreg_q;
    assign aluop     = aluop_q;
    assign state     = state_q;
    assign instret   = instret_q;

endmodule
